// File: rtl/uart_controller_pkg.sv
// Shared UART definitions: register map, STATUS bit positions and the
// four-phase frame state used by both the transmitter and the receiver.
`ifndef UART_ADDRESS_WIDTH
`define UART_ADDRESS_WIDTH 4
`endif

package uart_controller_pkg;

  localparam int ADDR_W = `UART_ADDRESS_WIDTH;

  localparam logic [ADDR_W-1:0] UART_REG_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] UART_REG_STATUS = ADDR_W'(1);

  localparam int ST_TX_READY  = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/bus_if.sv
// Simple single-cycle register bus; the slave never stalls.
`ifndef UART_ADDRESS_WIDTH
`define UART_ADDRESS_WIDTH 4
`endif

interface Bus_if;
  logic                           read;
  logic                           write;
  logic [`UART_ADDRESS_WIDTH-1:0] address;
  logic [31:0]                    data_wr;
  logic [31:0]                    data_rd;
  logic [3:0]                     mask;
  logic                           stall;

  modport master (output read, write, address, data_wr, mask, input data_rd, stall);
  modport slave  (input read, write, address, data_wr, mask, output data_rd, stall);
endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with wrap-bit pointers; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_controller.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers, TX byte FIFO feeding a
// transmit engine, and a mid-bit sampling receiver with sticky error flags.
module uart_controller
  import uart_controller_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115_200,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  Bus_if.slave bus,
  input  logic rxd,
  output logic txd,
  output logic irq
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_controller: CLK_FREQ/BAUD must be at least 4");
    end
    if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_controller: TX_FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // Register decode
  logic sel_data, sel_status;
  logic data_rd_hit, status_rd_hit, data_wr_hit;

  assign sel_data      = (bus.address == UART_REG_DATA);
  assign sel_status    = (bus.address == UART_REG_STATUS);
  assign data_rd_hit   = bus.read  && sel_data;
  assign status_rd_hit = bus.read  && sel_status;
  assign data_wr_hit   = bus.write && sel_data;
  assign bus.stall     = 1'b0;

  logic unused_bus;
  assign unused_bus = ^{bus.mask, bus.data_wr[31:8]};

  // Transmit path
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  uart_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_wr_hit),
    .wdata (bus.data_wr[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  uart_state_t      tx_state, tx_state_d;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]       tx_bit, tx_bit_d;
  logic [7:0]       tx_shift, tx_shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    fifo_pop   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = DATA;
        end else tx_cnt_d = tx_cnt + 1'b1;
      end
      DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) tx_state_d = STOP;
          else                tx_bit_d   = tx_bit + 1'b1;
        end else tx_cnt_d = tx_cnt + 1'b1;
      end
      STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
        end else tx_cnt_d = tx_cnt + 1'b1;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset forces the line high at once.
  always_comb begin
    case (tx_state)
      START:   txd = 1'b0;
      DATA:    txd = tx_shift[0];
      default: txd = 1'b1;
    endcase
  end

  // Receive path
  logic [1:0]       rx_sync;
  logic             rx_prev, rx_s;
  uart_state_t      rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic             rx_load, rx_ferr;
  logic [7:0]       rx_data;
  logic             rx_valid, overrun, frame_err;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_prev  <= rx_s;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_load    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = START;
        end
      end
      START: begin
        // Half-bit recheck rejects glitches and centres later samples.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? IDLE : DATA;
        end else rx_cnt_d = rx_cnt + 1'b1;
      end
      DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_d = STOP;
          else                rx_bit_d   = rx_bit + 1'b1;
        end else rx_cnt_d = rx_cnt + 1'b1;
      end
      STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          rx_load    = rx_s;
          rx_ferr    = !rx_s;
        end else rx_cnt_d = rx_cnt + 1'b1;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // A new byte wins over a same-cycle clear; flag sets win over STATUS clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (data_rd_hit) begin
        rx_valid <= 1'b0;
      end
      if (rx_load && rx_valid && !data_rd_hit) overrun <= 1'b1;
      else if (status_rd_hit)                  overrun <= 1'b0;
      if (rx_ferr)            frame_err <= 1'b1;
      else if (status_rd_hit) frame_err <= 1'b0;
    end
  end

  assign irq = rx_valid;

  always_comb begin
    bus.data_rd = '0;
    if (data_rd_hit) begin
      bus.data_rd = {24'b0, rx_data};
    end else if (status_rd_hit) begin
      bus.data_rd[ST_TX_READY]  = !fifo_full;
      bus.data_rd[ST_RX_VALID]  = rx_valid;
      bus.data_rd[ST_TX_IDLE]   = fifo_empty && (tx_state == IDLE);
      bus.data_rd[ST_OVERRUN]   = overrun;
      bus.data_rd[ST_FRAME_ERR] = frame_err;
    end
  end

endmodule

// File: tb/tb_uart_controller.sv
// Directed bench for uart_controller at DIV=16: TX waveform and FIFO overflow,
// RX data/overrun/framing/glitch handling, and asynchronous reset mid-byte.
module tb_uart_controller;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 16;
  localparam logic [`UART_ADDRESS_WIDTH-1:0] A_DATA   = `UART_ADDRESS_WIDTH'(0);
  localparam logic [`UART_ADDRESS_WIDTH-1:0] A_STATUS = `UART_ADDRESS_WIDTH'(1);

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;
  wire  txd;
  wire  irq;

  Bus_if bus_i ();

  uart_controller #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .TX_FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i),
    .rxd   (rxd),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  logic       mon_abort;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [`UART_ADDRESS_WIDTH-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_i.write   = 1'b1;
    bus_i.address = a;
    bus_i.data_wr = d;
    @(posedge clk);
    #1 bus_i.write = 1'b0;
  endtask

  task automatic bus_read(input logic [`UART_ADDRESS_WIDTH-1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_i.read    = 1'b1;
    bus_i.address = a;
    #1 d = bus_i.data_rd;
    @(posedge clk);
    #1 bus_i.read = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int budget);
    logic [31:0] s;
    s = '0;
    for (int n = 0; n < budget; n++) begin
      bus_read(A_STATUS, s);
      if (s[2]) break;
    end
    check("tx_idle_wait", 32'(s[2]), 32'd1);
  endtask

  task automatic mon_wait(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst_n) mon_abort = 1'b1;
    end
  endtask

  // Line decoder: samples each bit mid-cell and scores against tx_exp.
  initial begin : tx_monitor
    logic [7:0] got;
    logic       start_ok, stop_ok, have_exp;
    logic [7:0] exp_b;
    forever begin
      @(negedge txd);
      mon_abort = 1'b0;
      mon_wait(DIV / 2);
      start_ok = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        mon_wait(DIV);
        got[i] = txd;
      end
      mon_wait(DIV);
      stop_ok = (txd === 1'b1);
      if (!mon_abort) begin
        have_exp = (tx_exp.size() != 0);
        check("tx_frame_expected", 32'(have_exp), 32'd1);
        exp_b = have_exp ? tx_exp.pop_front() : 8'h00;
        check("tx_frame_byte", {22'b0, start_ok, stop_ok, got}, {22'b0, 2'b11, exp_b});
      end
    end
  end

  initial begin : global_timeout
    #400_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    logic [31:0] s;
    logic [9:0]  pat;
    logic [7:0]  exp_b;
    int          lat, bad, lows;

    rst_n         = 1'b0;
    rxd           = 1'b1;
    bus_i.read    = 1'b0;
    bus_i.write   = 1'b0;
    bus_i.address = '0;
    bus_i.data_wr = '0;
    bus_i.mask    = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("data_rd_idle_zero", bus_i.data_rd, 32'd0);
    bus_read(A_STATUS, s);
    check("status_after_reset", s & 32'h1E, 32'h04);
    check("tx_ready_after_reset", 32'(s[0]), 32'd1);
    bus_read(4'h5, s);
    check("unmapped_read_zero", s, 32'd0);

    // Single byte 0x55: exact waveform, cycle by cycle
    tx_exp.push_back(8'h55);
    bus_write(A_DATA, 32'h0000_0055);
    lat = 99;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        lat = c;
        break;
      end
    end
    check("tx_start_latency", 32'(lat), 32'd1);
    pat = {1'b1, 8'h55, 1'b0};
    bad = 0;
    for (int j = 0; j < 10 * DIV; j++) begin
      if (j != 0) @(negedge clk);
      if (txd !== pat[j / DIV]) bad++;
    end
    check("tx_0x55_waveform", 32'(bad), 32'd0);
    @(negedge clk);
    check("tx_line_idle_high", 32'(txd), 32'd1);
    wait_tx_idle(20);
    check("tx_queue_drained_1", 32'(tx_exp.size()), 32'd0);

    // Ten back-to-back writes: the first byte leaves for the shifter one
    // cycle after landing, so 0x00..0x08 fit and 0x09 is dropped.
    for (int k = 0; k < 9; k++) tx_exp.push_back(8'(k));
    for (int k = 0; k < 10; k++) bus_write(A_DATA, 32'(k));
    bus_read(A_STATUS, s);
    check("tx_ready_when_full", 32'(s[0]), 32'd0);
    wait_tx_idle(3000);
    check("tx_queue_drained_2", 32'(tx_exp.size()), 32'd0);

    // Receive 0xA3
    rx_exp.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    check("irq_on_rx", 32'(irq), 32'd1);
    exp_b = rx_exp.pop_front();
    bus_read(A_DATA, s);
    check("rx_data_a3", s, {24'b0, exp_b});
    check("irq_cleared_by_read", 32'(irq), 32'd0);

    // Two frames unread: newest byte kept, overrun flagged
    rx_exp.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    rx_exp.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    bus_read(A_STATUS, s);
    check("status_overrun", s & 32'h1A, 32'h0A);
    exp_b = rx_exp[$];
    rx_exp.delete();
    bus_read(A_DATA, s);
    check("rx_data_overwrite", s, {24'b0, exp_b});
    bus_read(A_STATUS, s);
    check("status_overrun_cleared", s & 32'h1A, 32'h00);

    // Stop bit low: framing error, byte discarded
    send_frame(8'h5C, 1'b0);
    bus_read(A_STATUS, s);
    check("status_frame_err", s & 32'h1A, 32'h10);
    check("irq_after_frame_err", 32'(irq), 32'd0);

    // Short low glitch: rejected without any flag
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(A_STATUS, s);
    check("status_after_glitch", s & 32'h1E, 32'h04);
    check("irq_after_glitch", 32'(irq), 32'd0);
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    exp_b = rx_exp.pop_front();
    bus_read(A_DATA, s);
    check("rx_data_after_glitch", s, {24'b0, exp_b});

    // Reset in the middle of a transmitted byte; queued bytes are lost
    bus_write(A_DATA, 32'h0000_00F0);
    bus_write(A_DATA, 32'h0000_000F);
    bus_write(A_DATA, 32'h0000_00AA);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (txd === 1'b0) break;
    end
    repeat (2 * DIV + 8) @(negedge clk);
    check("txd_low_before_reset", 32'(txd), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("txd_high_in_reset", 32'(txd), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_STATUS, s);
    check("status_after_mid_reset", s & 32'h1E, 32'h04);
    check("tx_ready_after_mid_reset", 32'(s[0]), 32'd1);
    lows = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("txd_quiet_after_reset", 32'(lows), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
